// File: rtl/id_ex_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: result-select codes, ALU op codes,
// the bubble encoding and the Tnew aging helper.
`default_nettype none

package id_ex_reg_pkg;

    localparam int WDSEL_W = 2;
    localparam int TNEW_W  = 2;

    localparam logic [WDSEL_W-1:0] WD_ALU = 2'b00;
    localparam logic [WDSEL_W-1:0] WD_DM  = 2'b01;
    localparam logic [WDSEL_W-1:0] WD_PC8 = 2'b10;

    localparam logic SIGN_EXT = 1'b1;
    localparam logic ZERO_EXT = 1'b0;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

    // Tnew one stage later, saturating at zero.
    function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (to zero) taking priority over the load enable.
`default_nettype none

module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the 5-stage MIPS core with hold, bubble and
// flush handling, $0 destination canonicalisation and Tnew tracking.
`default_nettype none

module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               hold,
    input  logic               bubble,
    input  logic [DW-1:0]      D_PC,
    input  logic [DW-1:0]      D_Instr,
    input  logic [DW-1:0]      D_RD1,
    input  logic [DW-1:0]      D_RD2,
    input  logic [DW-1:0]      D_EXT_Imm,
    input  logic [AW-1:0]      D_A1,
    input  logic [AW-1:0]      D_A2,
    input  logic [AW-1:0]      D_A3,
    input  logic               D_RegWrite,
    input  logic               D_MemWrite,
    input  logic               D_ALUSrc,
    input  logic [ALUOP_W-1:0] D_ALUop,
    input  logic [WDSEL_W-1:0] D_WDSel,
    input  logic [TNEW_W-1:0]  D_Tnew,
    output logic [DW-1:0]      E_PC,
    output logic [DW-1:0]      E_Instr,
    output logic [DW-1:0]      E_RD1,
    output logic [DW-1:0]      E_RD2,
    output logic [DW-1:0]      E_EXT_Imm,
    output logic [AW-1:0]      E_A1,
    output logic [AW-1:0]      E_A2,
    output logic [AW-1:0]      E_A3,
    output logic               E_RegWrite,
    output logic               E_MemWrite,
    output logic               E_ALUSrc,
    output logic [ALUOP_W-1:0] E_ALUop,
    output logic [WDSEL_W-1:0] E_WDSel,
    output logic [TNEW_W-1:0]  E_Tnew,
    output logic [TNEW_W-1:0]  E_Tnew_M,
    output logic               E_valid
);

    localparam int DATA_W = 5 * DW;
    localparam int ADDR_W = 3 * AW;
    localparam int CTRL_W = 4 + ALUOP_W + WDSEL_W;

    logic              w_en;
    logic              w_clr;
    logic              w_regwrite;
    logic [AW-1:0]     w_a3;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [TNEW_W-1:0] tnew_q;

    // flush beats hold; hold freezes everything, so a bubble under hold is dropped.
    assign w_clr = flush | (~hold & bubble);
    assign w_en  = ~hold;

    // A non-writing instr carries A3=0 and a write to $0 is dropped, so
    // forwarding only needs to test E_A3 != 0.
    assign w_regwrite = D_RegWrite & (D_A3 != '0);
    assign w_a3       = D_RegWrite ? D_A3 : '0;

    assign data_d = {D_PC, D_Instr, D_RD1, D_RD2, D_EXT_Imm};
    assign addr_d = {D_A1, D_A2, w_a3};
    assign ctrl_d = {1'b1, w_regwrite, D_MemWrite, D_ALUSrc, D_ALUop, D_WDSel};

    pipe_reg #(.W(DATA_W)) u_data (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (w_en),
        .clr_i (w_clr),
        .d_i   (data_d),
        .q_o   (data_q)
    );

    pipe_reg #(.W(ADDR_W)) u_addr (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (w_en),
        .clr_i (w_clr),
        .d_i   (addr_d),
        .q_o   (addr_q)
    );

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (w_en),
        .clr_i (w_clr),
        .d_i   (ctrl_d),
        .q_o   (ctrl_q)
    );

    pipe_reg #(.W(TNEW_W)) u_tnew (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (w_en),
        .clr_i (w_clr),
        .d_i   (D_Tnew),
        .q_o   (tnew_q)
    );

    assign {E_PC, E_Instr, E_RD1, E_RD2, E_EXT_Imm} = data_q;
    assign {E_A1, E_A2, E_A3}                       = addr_q;
    assign {E_valid, E_RegWrite, E_MemWrite, E_ALUSrc, E_ALUop, E_WDSel} = ctrl_q;

    assign E_Tnew   = tnew_q;
    assign E_Tnew_M = tnew_age(tnew_q);

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a rule-level model compared every cycle
// plus directed scenarios with literal expectations.
`default_nettype none

module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0, hold = 1'b0, bubble = 1'b0;
    logic [31:0] D_PC = '0, D_Instr = '0, D_RD1 = '0, D_RD2 = '0, D_EXT_Imm = '0;
    logic [4:0]  D_A1 = '0, D_A2 = '0, D_A3 = '0;
    logic        D_RegWrite = 1'b0, D_MemWrite = 1'b0, D_ALUSrc = 1'b0;
    logic [3:0]  D_ALUop = '0;
    logic [1:0]  D_WDSel = '0, D_Tnew = '0;

    logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_EXT_Imm;
    logic [4:0]  E_A1, E_A2, E_A3;
    logic        E_RegWrite, E_MemWrite, E_ALUSrc, E_valid;
    logic [3:0]  E_ALUop;
    logic [1:0]  E_WDSel, E_Tnew, E_Tnew_M;

    int checks = 0;
    int errors = 0;

    id_ex_reg #(.DW(32), .AW(5), .ALUOP_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold), .bubble(bubble),
        .D_PC(D_PC), .D_Instr(D_Instr), .D_RD1(D_RD1), .D_RD2(D_RD2), .D_EXT_Imm(D_EXT_Imm),
        .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3), .D_RegWrite(D_RegWrite), .D_MemWrite(D_MemWrite),
        .D_ALUSrc(D_ALUSrc), .D_ALUop(D_ALUop), .D_WDSel(D_WDSel), .D_Tnew(D_Tnew),
        .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2), .E_EXT_Imm(E_EXT_Imm),
        .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3), .E_RegWrite(E_RegWrite), .E_MemWrite(E_MemWrite),
        .E_ALUSrc(E_ALUSrc), .E_ALUop(E_ALUop), .E_WDSel(E_WDSel), .E_Tnew(E_Tnew),
        .E_Tnew_M(E_Tnew_M), .E_valid(E_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents of the E stage, as a list of field values.
    logic [31:0] m_pc = '0, m_instr = '0, m_rd1 = '0, m_rd2 = '0, m_imm = '0;
    int          m_a1 = 0, m_a2 = 0, m_a3 = 0, m_aluop = 0, m_wdsel = 0, m_tnew = 0;
    bit          m_rw = 0, m_mw = 0, m_alusrc = 0, m_valid = 0;

    task automatic model_kill();
        m_pc = '0; m_instr = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_a1 = 0; m_a2 = 0; m_a3 = 0; m_aluop = 0; m_wdsel = 0; m_tnew = 0;
        m_rw = 0; m_mw = 0; m_alusrc = 0; m_valid = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            model_kill();
        end else if (hold) begin
            // instruction stays put
        end else if (bubble) begin
            model_kill();
        end else begin
            m_pc = D_PC; m_instr = D_Instr; m_rd1 = D_RD1; m_rd2 = D_RD2; m_imm = D_EXT_Imm;
            m_a1 = int'(D_A1); m_a2 = int'(D_A2);
            m_a3 = D_RegWrite ? int'(D_A3) : 0;
            m_rw = D_RegWrite && (int'(D_A3) != 0);
            m_mw = D_MemWrite; m_alusrc = D_ALUSrc;
            m_aluop = int'(D_ALUop); m_wdsel = int'(D_WDSel); m_tnew = int'(D_Tnew);
            m_valid = 1;
        end
    end

    always @(negedge clk) begin
        chk("PC", E_PC, m_pc);
        chk("Instr", E_Instr, m_instr);
        chk("RD1", E_RD1, m_rd1);
        chk("RD2", E_RD2, m_rd2);
        chk("EXT_Imm", E_EXT_Imm, m_imm);
        chk("A1", 32'(E_A1), 32'(m_a1));
        chk("A2", 32'(E_A2), 32'(m_a2));
        chk("A3", 32'(E_A3), 32'(m_a3));
        chk("RegWrite", 32'(E_RegWrite), 32'(m_rw));
        chk("MemWrite", 32'(E_MemWrite), 32'(m_mw));
        chk("ALUSrc", 32'(E_ALUSrc), 32'(m_alusrc));
        chk("ALUop", 32'(E_ALUop), 32'(m_aluop));
        chk("WDSel", 32'(E_WDSel), 32'(m_wdsel));
        chk("Tnew", 32'(E_Tnew), 32'(m_tnew));
        chk("Tnew_M", 32'(E_Tnew_M), 32'((m_tnew > 0) ? m_tnew - 1 : 0));
        chk("valid", 32'(E_valid), 32'(m_valid));
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                         input logic [4:0] a3, input logic rw, input logic mw,
                         input logic [1:0] wd, input logic [1:0] tn);
        D_PC = pc; D_Instr = instr; D_EXT_Imm = imm;
        D_RD1 = pc ^ 32'h1111_0000; D_RD2 = instr ^ 32'h0000_2222;
        D_A1 = instr[25:21]; D_A2 = instr[20:16]; D_A3 = a3;
        D_RegWrite = rw; D_MemWrite = mw; D_ALUSrc = 1'b1;
        D_ALUop = pc[5:2]; D_WDSel = wd; D_Tnew = tn;
    endtask

    task automatic ctl(input logic f, input logic h, input logic b);
        flush = f; hold = h; bubble = b;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Reset mid-run with all-ones inputs clears asynchronously.
        D_PC = '1; D_Instr = '1; D_RD1 = '1; D_RD2 = '1; D_EXT_Imm = '1;
        D_A1 = '1; D_A2 = '1; D_A3 = '1; D_RegWrite = 1; D_MemWrite = 1; D_ALUSrc = 1;
        D_ALUop = '1; D_WDSel = '1; D_Tnew = '1;
        nxt();
        chk("ones_PC", E_PC, 32'hFFFF_FFFF);
        chk("ones_Tnew_M", 32'(E_Tnew_M), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("async_PC", E_PC, 32'h0);
        chk("async_A3", 32'(E_A3), 32'h0);
        chk("async_valid", 32'(E_valid), 32'h0);
        chk("async_Tnew", 32'(E_Tnew), 32'h0);
        nxt();
        reset = 1'b1;

        // addiu $8,$9,-4
        drive(32'h0000_3000, 32'h2528_FFFC, 32'hFFFF_FFFC, 5'd8, 1'b1, 1'b0, 2'b00, 2'd1);
        nxt();
        chk("addiu_Imm", E_EXT_Imm, 32'hFFFF_FFFC);
        chk("addiu_A3", 32'(E_A3), 32'd8);
        chk("addiu_Tnew", 32'(E_Tnew), 32'd1);
        chk("addiu_Tnew_M", 32'(E_Tnew_M), 32'd0);
        chk("addiu_valid", 32'(E_valid), 32'd1);

        // Hold for 3 edges while D changes.
        ctl(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_4000 + 32'(i * 4), 32'h0110_0000 + 32'(i), 32'(i), 5'(i + 1), 1'b1, 1'b0, 2'b00, 2'd2);
            nxt();
            chk("hold_PC", E_PC, 32'h0000_3000);
            chk("hold_Tnew", 32'(E_Tnew), 32'd1);
        end
        ctl(0, 0, 0);
        drive(32'h0000_5000, 32'h0232_4021, 32'h0, 5'd8, 1'b1, 1'b0, 2'b00, 2'd2);
        nxt();
        chk("unhold_PC", E_PC, 32'h0000_5000);
        chk("unhold_Tnew_M", 32'(E_Tnew_M), 32'd1);

        // Bubble with a valid lw in D.
        ctl(0, 0, 1);
        drive(32'h0000_5004, 32'h8D28_0004, 32'h4, 5'd8, 1'b1, 1'b0, 2'b01, 2'd2);
        nxt();
        chk("bub_valid", 32'(E_valid), 32'd0);
        chk("bub_RegWrite", 32'(E_RegWrite), 32'd0);
        chk("bub_MemWrite", 32'(E_MemWrite), 32'd0);
        chk("bub_Instr", E_Instr, 32'h0);
        // Reload the lw, then hold+bubble keeps it.
        ctl(0, 0, 0);
        nxt();
        chk("lw_WDSel", 32'(E_WDSel), 32'd1);
        ctl(0, 1, 1);
        drive(32'h0000_6000, 32'hAD2A_0008, 32'h8, 5'd0, 1'b0, 1'b1, 2'b00, 2'd0);
        nxt();
        chk("holdbub_Instr", E_Instr, 32'h8D28_0004);
        chk("holdbub_valid", 32'(E_valid), 32'd1);

        // flush wins over hold.
        ctl(1, 1, 0);
        nxt();
        chk("flush_valid", 32'(E_valid), 32'd0);
        chk("flush_PC", E_PC, 32'h0);

        // $0 canonicalisation: sw (no write) then write to $0, then jal-like write to $31 w/o RegWrite.
        ctl(0, 0, 0);
        nxt();
        chk("sw_MemWrite", 32'(E_MemWrite), 32'd1);
        drive(32'h0000_7000, 32'h0000_0021, 32'h0, 5'd0, 1'b1, 1'b0, 2'b00, 2'd1);
        nxt();
        chk("zero_RegWrite", 32'(E_RegWrite), 32'd0);
        chk("zero_valid", 32'(E_valid), 32'd1);
        drive(32'h0000_7004, 32'h0C00_1000, 32'h0, 5'd31, 1'b0, 1'b0, 2'b10, 2'd0);
        nxt();
        chk("norw_A3", 32'(E_A3), 32'd0);
        drive(32'h0000_7008, 32'h0C00_1000, 32'h0, 5'd31, 1'b1, 1'b0, 2'b10, 2'd0);
        nxt();
        chk("jal_A3", 32'(E_A3), 32'd31);
        chk("jal_RegWrite", 32'(E_RegWrite), 32'd1);

        // Reset asserted during hold, then a plain load after release.
        ctl(0, 1, 0);
        nxt();
        #1 reset = 1'b0;
        #1 chk("rsthold_valid", 32'(E_valid), 32'd0);
        nxt();
        reset = 1'b1;
        ctl(0, 0, 0);
        drive(32'h0000_8000, 32'h2402_000A, 32'hA, 5'd2, 1'b1, 1'b0, 2'b00, 2'd1);
        nxt();
        chk("postrst_PC", E_PC, 32'h0000_8000);

        // A few pseudo-random mixed cycles against the model.
        for (int i = 0; i < 40; i++) begin
            ctl(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            drive($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
            nxt();
        end

        @(posedge clk);
        #6;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
